// File: rtl/banyan_acq_ctl_if.sv
// Control/status and snapshot-memory handshake bundle for the banyan acquisition sequencer.
// The sequencer connects through the slave modport; software and the memory sit on the master side.
interface banyan_acq_ctl_if #(
   parameter int aw = 10
);
   logic            arm;
   logic            abort;
   logic            mode;
   logic            trig;
   logic            fault;
   logic [aw+2:0]   post_count;
   logic            mem_rollover;
   logic [aw+2:0]   mem_pointer;
   logic            mem_reset;
   logic            mem_run;
   logic            busy;
   logic            ready;
   logic            wrapped;
   logic [aw+2:0]   trig_ptr;
   logic [2:0]      state;

   modport slave (
      input  arm, abort, mode, trig, fault, post_count, mem_rollover, mem_pointer,
      output mem_reset, mem_run, busy, ready, wrapped, trig_ptr, state
   );

   modport master (
      output arm, abort, mode, trig, fault, post_count, mem_rollover, mem_pointer,
      input  mem_reset, mem_run, busy, ready, wrapped, trig_ptr, state
   );
endinterface

// File: rtl/banyan_acq_ctl.sv
// Acquisition sequencer for the 8-ADC banyan snapshot memory: one-shot and
// fault-triggered circular capture, with a drain window before data is reported ready.
module banyan_acq_ctl #(
   parameter int aw    = 10,
   parameter int drain = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   banyan_acq_ctl_if.slave bus
);
   localparam int pw = aw + 3;
   localparam int dw = (drain > 1) ? $clog2(drain) : 1;
   localparam logic [dw-1:0] drain_last = dw'(drain - 1);

   typedef enum logic [2:0] {
      st_idle      = 3'd0,
      st_wait_trig = 3'd1,
      st_fill      = 3'd2,
      st_circ      = 3'd3,
      st_post      = 3'd4,
      st_drain     = 3'd5,
      st_done      = 3'd6
   } state_t;

   state_t          state_r;
   logic            mem_reset_r;
   logic            mem_run_r;
   logic            busy_r;
   logic            ready_r;
   logic            wrapped_r;
   logic [pw-1:0]   trig_ptr_r;
   logic [pw-1:0]   post_cnt_r;
   logic [dw-1:0]   drain_cnt_r;

   // Sequencer state, memory controls and status flags, all registered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= st_idle;
         mem_reset_r <= 1'b0;
         mem_run_r   <= 1'b0;
         busy_r      <= 1'b0;
         ready_r     <= 1'b0;
         wrapped_r   <= 1'b0;
         trig_ptr_r  <= {pw{1'b0}};
         post_cnt_r  <= {pw{1'b0}};
         drain_cnt_r <= {dw{1'b0}};
      end else if (bus.abort) begin
         state_r     <= st_idle;
         mem_reset_r <= 1'b0;
         mem_run_r   <= 1'b0;
         busy_r      <= 1'b0;
         ready_r     <= 1'b0;
      end else begin
         mem_reset_r <= 1'b0;
         case (state_r)
            st_idle, st_done: begin
               if (bus.arm) begin
                  wrapped_r <= 1'b0;
                  ready_r   <= 1'b0;
                  busy_r    <= 1'b1;
                  if (bus.mode) begin
                     state_r     <= st_circ;
                     mem_reset_r <= 1'b1;
                     mem_run_r   <= 1'b1;
                  end else begin
                     state_r <= st_wait_trig;
                  end
               end
            end
            st_wait_trig: begin
               if (bus.trig) begin
                  state_r     <= st_fill;
                  mem_reset_r <= 1'b1;
                  mem_run_r   <= 1'b1;
               end
            end
            st_fill: begin
               if (bus.mem_rollover) begin
                  state_r     <= st_drain;
                  mem_run_r   <= 1'b0;
                  wrapped_r   <= 1'b1;
                  drain_cnt_r <= drain_last;
               end
            end
            st_circ: begin
               if (bus.mem_rollover) begin
                  wrapped_r <= 1'b1;
               end
               // A fault coinciding with the pointer-clear cycle refers to the old capture.
               if (bus.fault && !mem_reset_r) begin
                  trig_ptr_r <= bus.mem_pointer;
                  post_cnt_r <= bus.post_count;
                  state_r    <= st_post;
               end
            end
            st_post: begin
               if (bus.mem_rollover) begin
                  wrapped_r <= 1'b1;
               end
               if (post_cnt_r == {pw{1'b0}}) begin
                  state_r     <= st_drain;
                  mem_run_r   <= 1'b0;
                  drain_cnt_r <= drain_last;
               end else begin
                  post_cnt_r <= post_cnt_r - pw'(1'b1);
               end
            end
            st_drain: begin
               if (drain_cnt_r == {dw{1'b0}}) begin
                  state_r <= st_done;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end else begin
                  drain_cnt_r <= drain_cnt_r - dw'(1'b1);
               end
            end
            default: begin
               state_r   <= st_idle;
               mem_run_r <= 1'b0;
               busy_r    <= 1'b0;
               ready_r   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_reset = mem_reset_r;
   assign bus.mem_run   = mem_run_r;
   assign bus.busy      = busy_r;
   assign bus.ready     = ready_r;
   assign bus.wrapped   = wrapped_r;
   assign bus.trig_ptr  = trig_ptr_r;
   assign bus.state     = state_r;
endmodule

// File: doc/banyan_acq_ctl.md
Name: banyan_acq_ctl

Overview:
- Acquisition sequencer for the 8-ADC banyan snapshot memory.
- Drives the memory's reset/run controls and watches its rollover/pointer status.
- Two capture modes:
  - one-shot: wait for trigger, fill once, stop.
  - fault capture: record circularly until a fault, then continue for a programmable post-trigger count.
- Waits out the memory's write pipeline before reporting data ready; software reads only after ready.

Parameters:
- aw, 10: memory per-bank address width; pointer width is aw+3.
- drain, 4: clk cycles held in DRAIN after run drops, covering pipelined writes; must be >=1.

Ports:
- clk  input  1  sole clock; all logic rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- arm  input  1  single-cycle pulse; starts a capture from IDLE or DONE.
- abort  input  1  single-cycle pulse; returns to IDLE from any state.
- mode  input  1  0 = one-shot, 1 = fault capture; sampled on accepted arm.
- trig  input  1  one-shot start trigger, level-sampled in WAIT_TRIG.
- fault  input  1  fault-capture stop event, level-sampled in CIRC.
- post_count  input  aw+3  post-fault samples; sampled on fault acceptance.
- mem_rollover  input  1  memory rollover strobe, combinational from mem_run.
- mem_pointer  input  aw+3  memory write pointer.
- mem_reset  output  1  registered; one-cycle pulse clearing the memory pointer and full flag.
- mem_run  output  1  registered; memory write enable.
- busy  output  1  high in WAIT_TRIG, FILL, CIRC, POST and DRAIN.
- ready  output  1  high only in DONE.
- wrapped  output  1  capture rolled over at least once.
- trig_ptr  output  aw+3  mem_pointer latched on the fault-acceptance cycle.
- state  output  3  current state encoding, for status readback.

Behaviour:
- Reset (reset_n low): state=IDLE(0). All outputs 0, including trig_ptr; internal counters 0.
- State encodings: IDLE=0, WAIT_TRIG=1, FILL=2, CIRC=3, POST=4, DRAIN=5, DONE=6.
- Priority each cycle: abort > arm > trig/fault/rollover/counter events.
  - Abort: next cycle state=IDLE, mem_run=0, mem_reset=0, ready=0. wrapped and trig_ptr hold.
- arm in IDLE or DONE:
  - Clears wrapped and ready and latches mode.
  - mode=0: next state WAIT_TRIG.
  - mode=1: next cycle mem_reset=1 and mem_run=1, state CIRC.
- arm in any other state: ignored.
- WAIT_TRIG: trig high -> next cycle mem_reset=1 (exactly one cycle), mem_run=1, state FILL.
- FILL:
  - mem_rollover high -> next cycle mem_run=0, wrapped=1, state DRAIN.
  - trig is ignored.
- CIRC:
  - mem_rollover sets wrapped; run continues.
  - fault is ignored on the first CIRC cycle (the mem_reset cycle).
  - fault accepted -> trig_ptr<=mem_pointer, post counter<=post_count, state POST.
- POST:
  - Counter decrements each cycle. The cycle it reads 0 -> next cycle mem_run=0, state DRAIN.
  - post_count=0 therefore yields exactly one POST cycle.
  - mem_rollover continues to set wrapped.
  - Further fault pulses are ignored.
- DRAIN: mem_run=0; after exactly `drain` cycles -> DONE, ready=1.
- DONE: holds until arm or abort.
- mem_reset is high only for the one cycle after the start event. mem_run is never high in IDLE, WAIT_TRIG, DRAIN or DONE.
- Unused encoding 7 -> IDLE next cycle.
- Counter width is aw+3. No wrap: the counter loads post_count and only decrements to 0.

Test Plan:
1. One-shot, aw=3 (64-deep pointer):
   - Stimulus: arm, mode=0; trig 5 cycles later; memory model rollover at pointer 63.
   - Required: mem_reset pulses 1 cycle; mem_run high 64 cycles; state 2->5; ready rises 4 cycles after mem_run falls; wrapped=1.
2. Fault capture:
   - Stimulus: arm, mode=1; fault at pointer 37; post_count=10.
   - Required: trig_ptr=37; mem_run falls 11 cycles after fault acceptance; ready 4 cycles later; wrapped=0 if no rollover occurred.
3. Fault after wrap:
   - Stimulus: mode=1; let the pointer roll over twice; fault at pointer 12; post_count=0.
   - Required: wrapped=1; trig_ptr=12; exactly one POST cycle; then DRAIN.
4. Abort mid-POST, and abort+arm in the same cycle:
   - Required: next cycle state=0, mem_run=0, ready=0, trig_ptr held.
   - A later arm restarts correctly with a fresh mem_reset pulse.
5. Ignored events:
   - Stimulus: arm while in FILL; trig during CIRC; fault on the first CIRC cycle; second fault in POST.
   - Required: no state change or trig_ptr update from any of them.
6. Async reset asserted mid-FILL:
   - Required: all outputs 0 immediately, without waiting for a clk edge.
   - After release, state=IDLE; arm works.
